// File: rtl/acc_vmul_engine.sv
// ============================================================================
// Module   : acc_vmul_engine
// Brief    : Sequential element-wise 8x8 vector multiplier with a running
//            dot-product sum. Optional macro ACC_VMUL_SIGNED_EN selects
//            two's-complement operands.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module acc_vmul_engine #(
    parameter int DEPTH  = 16,
    parameter int AW_IN  = $clog2(DEPTH / 4),
    parameter int AW_OUT = $clog2(DEPTH / 2)
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              wr_en,
    input  logic              wr_sel,
    input  logic [AW_IN-1:0]  wr_addr,
    input  logic [31:0]       wr_data,
    input  logic              start,
    output logic              busy,
    output logic              done,
    input  logic [AW_OUT-1:0] rd_addr,
    output logic [31:0]       rd_data,
    output logic [31:0]       dot_out
);

    localparam int                 c_IDX_W = $clog2(DEPTH);
    localparam logic [c_IDX_W-1:0] c_LAST  = c_IDX_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t               r_state;
    logic [c_IDX_W-1:0]   r_idx;
    logic [7:0]           r_a [DEPTH];
    logic [7:0]           r_b [DEPTH];
    logic [15:0]          r_r [DEPTH];
    logic [15:0]          r_p;
    logic [c_IDX_W-1:0]   r_p_idx;
    logic                 r_p_vld;
    logic                 r_busy;
    logic                 r_done;
    logic [31:0]          r_dot;

    logic [7:0]           w_a;
    logic [7:0]           w_b;
    logic [15:0]          w_ea;
    logic [15:0]          w_eb;
    logic [15:0]          w_prod;
    logic [31:0]          w_pext;

    assign w_a = r_a[r_idx];
    assign w_b = r_b[r_idx];

    // Low 16 bits of the product of 16-bit extended operands equal the exact
    // 8x8 product in both signed and unsigned interpretation.
`ifdef ACC_VMUL_SIGNED_EN
    assign w_ea   = {{8{w_a[7]}}, w_a};
    assign w_eb   = {{8{w_b[7]}}, w_b};
    assign w_pext = {{16{r_p[15]}}, r_p};
`else
    assign w_ea   = {8'h00, w_a};
    assign w_eb   = {8'h00, w_b};
    assign w_pext = {16'h0000, r_p};
`endif
    assign w_prod = w_ea * w_eb;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_p     <= '0;
            r_p_idx <= '0;
            r_p_vld <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_dot   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_a[i] <= '0;
                r_b[i] <= '0;
                r_r[i] <= '0;
            end
        end else begin
            r_p_vld <= 1'b0;
            if (r_p_vld) begin
                r_r[r_p_idx] <= r_p;
                r_dot        <= r_dot + w_pext;
            end
            if (wr_en && (r_state == S_IDLE || r_state == S_DONE)) begin
                for (int k = 0; k < 4; k++) begin
                    if (wr_sel)
                        r_b[{wr_addr, k[1:0]}] <= wr_data[8*k +: 8];
                    else
                        r_a[{wr_addr, k[1:0]}] <= wr_data[8*k +: 8];
                end
            end
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_RUN;
                        r_idx   <= '0;
                        r_dot   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                S_RUN: begin
                    r_p     <= w_prod;
                    r_p_idx <= r_idx;
                    r_p_vld <= 1'b1;
                    r_idx   <= r_idx + 1'b1;
                    if (r_idx == c_LAST)
                        r_state <= S_DRAIN;
                end
                S_DRAIN: begin
                    r_state <= S_DONE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign dot_out = r_dot;
    assign rd_data = {r_r[{rd_addr, 1'b1}], r_r[{rd_addr, 1'b0}]};

endmodule

`default_nettype wire

// File: tb/tb_acc_vmul_engine.sv
// ============================================================================
// Module   : tb_acc_vmul_engine
// Brief    : Self-checking bench for acc_vmul_engine against an arithmetic
//            model of the operand vectors.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_acc_vmul_engine;

    localparam int DEPTH = 16;

    logic        HCLK = 1'b0;
    logic        HRESET = 1'b1;
    logic        wr_en = 1'b0;
    logic        wr_sel = 1'b0;
    logic [1:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic        start = 1'b0;
    logic        busy;
    logic        done;
    logic [2:0]  rd_addr = '0;
    logic [31:0] rd_data;
    logic [31:0] dot_out;

    int n_pass  = 0;
    int n_total = 0;
    int ma [DEPTH];
    int mb [DEPTH];

    acc_vmul_engine #(.DEPTH(DEPTH)) u_dut (
        .HCLK    (HCLK),
        .HRESET  (HRESET),
        .wr_en   (wr_en),
        .wr_sel  (wr_sel),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .dot_out (dot_out)
    );

    always #5 HCLK = ~HCLK;

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    function automatic int prod(input int i);
        int a, b;
        a = ma[i];
        b = mb[i];
`ifdef ACC_VMUL_SIGNED_EN
        if (a > 127) a -= 256;
        if (b > 127) b -= 256;
`endif
        return a * b;
    endfunction

    function automatic logic [31:0] exp_word(input int w);
        logic [31:0] lo, hi;
        lo = prod(2 * w);
        hi = prod(2 * w + 1);
        return {hi[15:0], lo[15:0]};
    endfunction

    function automatic logic [31:0] exp_dot();
        int s = 0;
        for (int i = 0; i < DEPTH; i++) s += prod(i);
        return s;
    endfunction

    // Writes an operand word while idle and mirrors it into the model.
    task automatic write_word(input logic sel, input int addr, input logic [31:0] data);
        wr_en = 1'b1; wr_sel = sel; wr_addr = addr[1:0]; wr_data = data;
        for (int k = 0; k < 4; k++) begin
            if (sel) mb[4*addr+k] = data[8*k +: 8];
            else     ma[4*addr+k] = data[8*k +: 8];
        end
        tick();
        wr_en = 1'b0;
    endtask

    // Issues start (caller may pre-drive a write), then checks the busy/done
    // timeline and final results. With disturb set, writes and extra starts
    // are driven mid-run and must be ignored.
    task automatic run_and_check(input string tag, input bit disturb);
        start = 1'b1;
        tick();
        start = 1'b0;
        wr_en = 1'b0;
        for (int c = 1; c <= 18; c++) begin
            check({tag, "_busy"}, 32'(busy), 32'(c <= 17));
            check({tag, "_done"}, 32'(done), 32'(c == 18));
            if (c < 18) begin
                if (disturb && c >= 2 && c <= 8) begin
                    wr_en = 1'b1; wr_sel = c[0]; wr_addr = c[1:0];
                    wr_data = $urandom; start = 1'b1;
                end else begin
                    wr_en = 1'b0; start = 1'b0;
                end
                tick();
            end
        end
        for (int w = 0; w < DEPTH / 2; w++) begin
            rd_addr = w[2:0];
            #1;
            check({tag, "_rd"}, rd_data, exp_word(w));
        end
        check({tag, "_dot"}, dot_out, exp_dot());
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin ma[i] = 0; mb[i] = 0; end

        // Reset state
        tick(); tick();
        HRESET = 1'b0;
        for (int w = 0; w < DEPTH / 2; w++) begin
            rd_addr = w[2:0];
            #1;
            check("reset_rd", rd_data, 32'h0);
        end
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_done", 32'(done), 32'h0);
        check("reset_dot", dot_out, 32'h0);

        // Directed ramp times two
        write_word(1'b0, 0, 32'h04030201);
        write_word(1'b0, 1, 32'h08070605);
        write_word(1'b0, 2, 32'h0C0B0A09);
        write_word(1'b0, 3, 32'h100F0E0D);
        for (int w = 0; w < 4; w++) write_word(1'b1, w, 32'h02020202);
        run_and_check("ramp", 1'b0);
        rd_addr = 3'd0; #1;
        check("ramp_rd0", rd_data, 32'h00040002);
        rd_addr = 3'd7; #1;
        check("ramp_rd7", rd_data, 32'h0020001E);
        check("ramp_dot272", dot_out, 32'd272);

        // Mid-run writes and starts are dropped; exactly one done
        run_and_check("disturb", 1'b1);
        for (int c = 0; c < 6; c++) begin
            tick();
            check("disturb_no_requeue", 32'({busy, done}), 32'h0);
        end
        run_and_check("operands_kept", 1'b0);

        // All ones
        for (int w = 0; w < 4; w++) begin
            write_word(1'b0, w, 32'hFFFFFFFF);
            write_word(1'b1, w, 32'hFFFFFFFF);
        end
        run_and_check("allff", 1'b0);
`ifdef ACC_VMUL_SIGNED_EN
        check("allff_dot", dot_out, 32'd16);
`else
        check("allff_dot", dot_out, 32'h000FE010);
`endif

        // Random vectors
        for (int r = 0; r < 4; r++) begin
            for (int w = 0; w < 4; w++) begin
                write_word(1'b0, w, $urandom);
                write_word(1'b1, w, $urandom);
            end
            run_and_check("random", 1'b0);
        end

        // Reset in the fifth RUN cycle
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 5; c++) tick();
        HRESET = 1'b1;
        tick();
        HRESET = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin ma[i] = 0; mb[i] = 0; end
        check("midreset_busy", 32'(busy), 32'h0);
        check("midreset_dot", dot_out, 32'h0);
        for (int w = 0; w < DEPTH / 2; w++) begin
            rd_addr = w[2:0];
            #1;
            check("midreset_rd", rd_data, 32'h0);
        end
        begin
            int dones = 0;
            for (int c = 0; c < 30; c++) begin
                if (done) dones++;
                tick();
            end
            check("midreset_no_done", dones, 0);
        end

        // Write and start in the same idle cycle
        write_word(1'b1, 0, 32'h00000003);
        wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 2'd0; wr_data = 32'h00000009;
        ma[0] = 9;
        run_and_check("wr_with_start", 1'b0);
        rd_addr = 3'd0; #1;
        check("wr_with_start_r0", {16'h0, rd_data[15:0]}, 32'd27);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/acc_vmul_engine.md
Name: acc_vmul_engine

Overview:
- Compute core that sits directly below the accelerator APB slave.
- Holds two operand vectors of DEPTH 8-bit elements and multiplies them element-wise into DEPTH 16-bit results.
- Also produces a running dot-product sum.
- The APB slave writes operand words, pulses start, waits for done and reads results; the core is a sequential, one-product-per-cycle engine.

Parameters:
- DEPTH, 16, number of elements per vector; power of 2, at least 4.
- AW_IN, $clog2(DEPTH/4), operand word address width (4 bytes per word).
- AW_OUT, $clog2(DEPTH/2), result word address width (2 results per word).

Ports:
- HCLK  in  1  clock; all logic on its rising edge.
- HRESET  in  1  synchronous, active-high reset.
- wr_en  in  1  operand write strobe.
- wr_sel  in  1  0 = vector A, 1 = vector B.
- wr_addr  in  AW_IN  operand word index.
- wr_data  in  32  byte k (bits 8k+7:8k) goes to element 4*wr_addr+k.
- start  in  1  single-cycle request to begin computation.
- busy  out  1  high while computing.
- done  out  1  one-cycle pulse when results are valid.
- rd_addr  in  AW_OUT  result word index.
- rd_data  out  32  bits [15:0] = R[2*rd_addr], bits [31:16] = R[2*rd_addr+1]; combinational.
- dot_out  out  32  sum of all products of the last run; registered.

Behaviour:
- Reset (HRESET high at an edge):
  - state goes to IDLE.
  - busy=0, done=0, dot_out=0.
  - A, B and R buffers are cleared to 0; the pipeline is emptied.
  - This applies at any time, including mid-run: no done pulse is issued and partial results are discarded.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE -> RUN when start=1. On that edge: dot_out <= 0, idx <= 0.
  - RUN: each cycle issues element idx. Pipeline stage 1 registers p = A[idx]*B[idx] (16 bit) with p_idx and p_vld. idx increments. After issuing idx=DEPTH-1, go to DRAIN.
  - Stage-2 writeback (in any state, whenever p_vld=1): R[p_idx] <= p and dot_out <= dot_out + zero-extended p, modulo 2^32.
  - DRAIN: lasts one cycle, retires the last product, then goes to DONE.
  - DONE: lasts one cycle, done=1, then returns to IDLE.
- Outputs by state: busy=1 in RUN and DRAIN, else 0. done=1 only in DONE.
- Latency: with start sampled at edge T, RUN spans cycles T+1..T+DEPTH, DRAIN is T+DEPTH+1, and done=1 in cycle T+DEPTH+2. At that point R and dot_out are final.
- Start acceptance: start is honoured only in IDLE. It is ignored in RUN, DRAIN and DONE; no queuing.
- Operand writes:
  - Accepted in IDLE and DONE; ignored (dropped) while busy=1.
  - A write and a start in the same IDLE cycle: the write lands on that edge, and the run uses the new data.
- Reads:
  - rd_data is always available.
  - While busy, it shows a mix of old and new R; the values are defined per element by whether writeback has occurred.
- R and dot_out hold their values until the next start or reset.

Optional Feature:
- Macro: ACC_VMUL_SIGNED_EN.
- Defined:
  - Operands are two's complement.
  - The product is a signed 16-bit value.
  - dot_out accumulates the sign-extended product.
- Undefined: operands and products are unsigned, and the accumulation is zero-extended.
- Timing and interface are identical in both builds.

Test Plan:
1. Reset, then sweep rd_addr 0..7 (DEPTH=16). Expect rd_data=0, busy=0, done=0, dot_out=0.
2. Write A words 0x04030201, 0x08070605, 0x0C0B0A09, 0x100F0E0D, all B words 0x02020202, then start at edge T.
   - busy high for cycles T+1..T+17; done pulses only in cycle T+18.
   - rd_addr 0 reads 0x00040002; rd_addr 7 reads 0x0020001E.
   - dot_out = 272 (0x110).
3. All A and B bytes 0xFF, then start.
   - Unsigned build: every result is 0xFE01 and dot_out=0x000FE010.
   - ACC_VMUL_SIGNED_EN build: every result is 0x0001 and dot_out=16.
4. During RUN, drive wr_en with new data and a second start.
   - Results match scenario 2 exactly.
   - Only one done pulse.
   - Operands unchanged afterwards.
5. Assert HRESET for one cycle in RUN cycle T+5.
   - Next cycle: busy=0, dot_out=0, all rd_data=0.
   - No done pulse within 30 cycles.
6. In one IDLE cycle, write A word 0 = 0x00000009 together with start, with B element 0 = 3. Expect R[0]=27 after done.
